// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the register file, control unit and the RV32M muldiv unit.
// The master side issues operations and the slave side is the execution unit.
interface muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] rs1_val;
    logic [WIDTH-1:0] rs2_val;
    logic [4:0]       rd_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [4:0]       rd_out;

    modport master (
        output start, funct3, rs1_val, rs2_val, rd_in,
        input  busy, done, result, rd_out
    );

    modport slave (
        input  start, funct3, rs1_val, rs2_val, rd_in,
        output busy, done, result, rd_out
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle, with the sign fix-up applied as the last iteration completes.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic           CLK,
    input logic           reset_n,
    muldiv_unit_if.slave  bus
);
    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    count_q, count_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_mag_q, a_mag_d;
    logic [WIDTH-1:0]   b_mag_q, b_mag_d;
    logic               neg_q, neg_d;
    logic               neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [4:0]         rd_q, rd_d;

    logic               a_signed, b_signed, sign_a, sign_b;
    logic [WIDTH-1:0]   a_mag_in, b_mag_in;
    logic               div_zero, div_ovf, div_special;
    logic [WIDTH-1:0]   special_res;
    logic [WIDTH:0]     mul_sum, rem_sh, rem_diff;
    logic [2*WIDTH-1:0] mul_next, div_next, acc_step, prod;
    logic [WIDTH-1:0]   quo, rem, final_res;

    // Operand decode at the start edge.
    always_comb begin
        a_signed = bus.funct3 inside {3'b001, 3'b010, 3'b100, 3'b110};
        b_signed = bus.funct3 inside {3'b001, 3'b100, 3'b110};
        sign_a   = a_signed & bus.rs1_val[WIDTH-1];
        sign_b   = b_signed & bus.rs2_val[WIDTH-1];
        a_mag_in = sign_a ? -bus.rs1_val : bus.rs1_val;
        b_mag_in = sign_b ? -bus.rs2_val : bus.rs2_val;
        div_zero = bus.rs2_val == '0;
        div_ovf  = (bus.funct3 inside {3'b100, 3'b110}) && (bus.rs1_val == MinNeg) &&
                   (bus.rs2_val == '1);
        div_special = bus.funct3[2] & (div_zero | div_ovf);
        if (div_zero) begin
            special_res = bus.funct3[1] ? bus.rs1_val : '1;
        end else begin
            special_res = bus.funct3[1] ? '0 : MinNeg;
        end
    end

    // One iteration: acc holds {partial, multiplier} for multiply, {remainder, dividend} for divide.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_mag_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, b_mag_q};
        div_next = {(rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0]),
                    acc_q[WIDTH-2:0], ~rem_diff[WIDTH]};
        acc_step = op_q[2] ? div_next : mul_next;
        prod     = neg_q ? -acc_step : acc_step;
        quo      = neg_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
        rem      = neg_rem_q ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
        final_res = '0;
        unique case (op_q)
            3'b000:                 final_res = prod[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         final_res = quo;
            default:                final_res = rem;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        op_d      = op_q;
        a_mag_d   = a_mag_q;
        b_mag_d   = b_mag_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        acc_d     = acc_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        result_d  = result_q;
        rd_d      = rd_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    op_d      = bus.funct3;
                    rd_d      = bus.rd_in;
                    a_mag_d   = a_mag_in;
                    b_mag_d   = b_mag_in;
                    neg_d     = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    count_d   = '0;
                    busy_d    = 1'b1;
                    acc_d     = {{WIDTH{1'b0}}, (bus.funct3[2] ? a_mag_in : b_mag_in)};
                    if (div_special) begin
                        result_d = special_res;
                        done_d   = 1'b1;
                        state_d  = StDone;
                    end else begin
                        state_d  = StCalc;
                    end
                end
            end
            StCalc: begin
                acc_d   = acc_step;
                count_d = count_q + 1'b1;
                if (count_q == CntW'(WIDTH - 1)) begin
                    result_d = final_res;
                    done_d   = 1'b1;
                    state_d  = StDone;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            count_q   <= '0;
            op_q      <= '0;
            a_mag_q   <= '0;
            b_mag_q   <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            rd_q      <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            op_q      <= op_d;
            a_mag_q   <= a_mag_d;
            b_mag_q   <= b_mag_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            acc_q     <= acc_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            rd_q      <= rd_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.rd_out = rd_q;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit. Sits directly downstream of the register file and consumes its read ports: RD1 drives rs1_val and RD2 drives rs2_val.
- Produces a 32-bit result plus a destination index and a one-cycle write strobe. These feed the register file write port (WD3, A3, WE3).
- Multi-cycle with a start/busy/done handshake. The control unit stalls the pipeline while busy is high.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled on posedge only when the unit is idle.
- funct3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_val  in  WIDTH  operand A, from register file RD1.
- rs2_val  in  WIDTH  operand B, from register file RD2.
- rd_in  in  5  destination register index.
- busy  out  1  high in CALC and DONE states.
- done  out  1  one-cycle completion pulse; drives register file WE3.
- result  out  WIDTH  final value; drives WD3.
- rd_out  out  5  latched destination index; drives A3.

Behaviour:
- Clock and reset: one clock CLK; reset is asynchronous and active-low on reset_n.
- Reset values: state=IDLE, busy=0, done=0, result=0, rd_out=0, all internal registers 0.
- Reset asserted mid-operation aborts immediately; no done pulse is issued for the aborted op.
- FSM states: IDLE, CALC, DONE.
- IDLE: start=1 at a posedge latches funct3, rd_in, operand magnitudes and sign flags.
  - Next state is CALC with count=0.
  - Special division case detected: next state is DONE directly.
- CALC: one iteration per cycle; count increments. After the iteration with count=WIDTH-1, next state is DONE.
- DONE: done=1 for exactly one cycle with result and rd_out valid. Next state is IDLE.
- Latency: normal ops raise done 33 cycles after the start edge; special division cases raise done 1 cycle after.
- result and rd_out hold their values after DONE until the next accepted start.
- start while busy=1 is ignored and not queued. start in the DONE cycle is also ignored.
- A new op is accepted the first cycle back in IDLE, giving back-to-back throughput of one op per 34 cycles.
- Signedness:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU, MUL: both unsigned. MUL's low word is sign-agnostic.
- Multiply: shift-add on operand magnitudes into a 2*WIDTH-bit accumulator. Final product is negated if sign(A)^sign(B).
  - MUL returns product[WIDTH-1:0]; MULH, MULHSU and MULHU return product[2*WIDTH-1:WIDTH].
- Divide: restoring division on magnitudes, one quotient bit per cycle, MSB first.
  - Quotient is negated if sign(A)^sign(B); remainder is negated if sign(A).
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special division cases, decided at start:
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give rs1_val.
  - Signed overflow, DIV with rs1=0x80000000 and rs2=0xFFFFFFFF: result 0x80000000; REM gives 0.
- Write strobe: done is asserted even when rd_out=0. The register file discards writes to x0.
- Timing: done spans a full cycle, so the register file's negedge write lands mid-DONE.
- Operand latching: operands are captured at the start edge. Changes on rs1_val/rs2_val during CALC have no effect.

Test Plan:
- MUL 7 x 6, rd=5 -> busy rises next cycle; done one cycle exactly 33 cycles after start; result=42, rd_out=5.
- MULH 0xFFFFFFFF (-1) x 0x00000002 -> result 0xFFFFFFFF. MULHU on the same operands -> 0x00000001. MULHSU on the same operands -> 0xFFFFFFFF.
- DIV -7 / 2 -> result 0xFFFFFFFD (-3). REM -7 / 2 -> 0xFFFFFFFF (-1). DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- Divide by zero: DIVU 5 / 0 -> 0xFFFFFFFF and REMU 5 / 0 -> 5, each with done 1 cycle after start. Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- Handshake: pulse start again at cycles 10 and 20 after an accepted start, with different operands -> both ignored. Only one done pulse occurs, carrying the original result; a start on the first IDLE cycle after done is accepted.
- Reset: assert reset_n=0 at cycle 15 of CALC -> busy, done, result and rd_out are 0 immediately. After release, no done pulse appears until a new start is accepted.
